dmem_mmio_bus: RTL and testbench
================================

# dmem_mmio_bus

Parametrised data-memory and memory-mapped I/O slave for the single-cycle RISC-V core's load/store port. Decodes the data address into a byte-addressable data RAM with sub-word loads/stores, an LED output register, a synchronised and debounced switch input, and a free-running timer with a compare flag. Sits between the core's execute/memory stage and the board I/O; the core sees a single combinational-read, posedge-write data port.

## Interface
Parameters:
- DM_BASE, 32'h0000_4000, byte address of data-RAM word 0
- DM_AW, 14, word-address width; RAM holds 2^DM_AW 32-bit words
- LED_W, 32, LED register width (1..32)
- SW_W, 24, switch input width (1..32)
- DEB_CYCLES, 20'd500000, stable cycles required before a switch change is accepted (≥2)
- TMR_PRESCALE, 100, clk_i cycles per timer tick (≥1)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- addr  in  32  byte address
- wen  in  1  store strobe
- size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- ld_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
- datain  in  32  store data, right-aligned
- device_sw  in  SW_W  asynchronous board switches
- dataout  out  32  load data (combinational)
- device_led  out  LED_W  LED register
- misalign_o  out  1  access misaligned (combinational)
- tmr_flag_o  out  1  timer compare flag (sticky)

## Operation
- Address map: RAM at DM_BASE .. DM_BASE+4·2^DM_AW−1; LED 0xFFFF_F000 (RW); SW 0xFFFF_F070 (RO); TMR_CNT 0xFFFF_F020 (RW); TMR_CMP 0xFFFF_F024 (RW); TMR_STAT 0xFFFF_F028 (bit0 = flag, write 1 to clear). Anything else: read 0, write ignored.
- Misalignment: half with addr[0]=1, word with addr[1:0]≠0 → misalign_o=1, write suppressed, dataout=0. MMIO registers are word-only; sub-word MMIO access is misaligned.
- RAM store: byte lanes enabled by size and addr[1:0]; datain[7:0]/[15:0] replicated onto the selected lane(s).
- RAM load: word read, lane selected by addr[1:0], extended per ld_unsigned.
- LED: word store loads datain[LED_W-1:0]; read returns zero-extended value.
- SW: device_sw passes a 2-flop synchroniser; read returns zero-extended accepted value.
- Timer: prescaler counts 0..TMR_PRESCALE−1; at wrap TMR_CNT increments (32-bit, wraps to 0). When TMR_CNT becomes equal to TMR_CMP on a tick, flag sets. CPU write to TMR_CNT loads value and resets the prescaler; no increment that cycle. Set and W1C in same cycle: set wins.
- RAM contents are not reset.

## Timing
- Reset values: device_led=0, TMR_CNT=0, TMR_CMP=32'hFFFF_FFFF, flag=0, prescaler=0, synchroniser/debounce state=0; outputs follow asynchronously.
- Loads: dataout valid same cycle as addr. Stores: committed at next rising edge; load of same address in following cycle returns new data.
- Switch latency without debounce: 2 cycles from device_sw change to readable.
- Reset asserted mid-store: store dropped; registers return to reset values immediately.

## Configuration
- SW_DEBOUNCE_EN defined: single shared counter restarts whenever synchronised vector differs from previous cycle; when it reaches DEB_CYCLES−1 the synchronised vector is copied to the accepted value. Change latency = 2 + DEB_CYCLES cycles; glitches shorter than DEB_CYCLES are never seen.
- Not defined: accepted value = synchroniser output; DEB_CYCLES unused.

## Test plan
- Store word 32'h1122_3344 to DM_BASE, then sb 8'hAA to DM_BASE+1 → word load reads 32'h1122_AA44; lb signed DM_BASE+1 → 32'hFFFF_FFAA; lbu → 32'h0000_00AA.
- sh to DM_BASE+3 with wen → misalign_o=1, RAM unchanged; sw to 0xFFFF_F000 with 32'h0000_00F0 → device_led=0xF0 next edge.
- device_sw=24'h00_00A5 (debounce off) → read of 0xFFFF_F070 returns 32'h0000_00A5 after 2 cycles; with SW_DEBOUNCE_EN and DEB_CYCLES=4, a 3-cycle glitch is ignored, a held value appears after 6 cycles.
- TMR_PRESCALE=2, write TMR_CMP=3, TMR_CNT=0 → flag set 6 cycles later; W1C to 0xFFFF_F028 clears it.
- Assert rst_i mid-stream after LED/timer writes → device_led=0, TMR_CNT=0, flag=0 without a clock edge; earlier RAM contents still readable.

Source files
------------

// File: rtl/dmem_mmio_bus.sv
// Data RAM plus LED / switch / timer MMIO slave on the core's load/store port.
// Define SW_DEBOUNCE_EN to debounce the synchronised switch vector.
module dmem_mmio_bus #(
    parameter logic [31:0] DM_BASE      = 32'h0000_4000,
    parameter int          DM_AW        = 14,
    parameter int          LED_W        = 32,
    parameter int          SW_W         = 24,
    parameter int          DEB_CYCLES   = 500000,
    parameter int          TMR_PRESCALE = 100
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      addr,
    input  logic             wen,
    input  logic [1:0]       size,
    input  logic             ld_unsigned,
    input  logic [31:0]      datain,
    input  logic [SW_W-1:0]  device_sw,
    output logic [31:0]      dataout,
    output logic [LED_W-1:0] device_led,
    output logic             misalign_o,
    output logic             tmr_flag_o
);
    localparam logic [31:0] LED_ADDR  = 32'hFFFF_F000;
    localparam logic [31:0] SW_ADDR   = 32'hFFFF_F070;
    localparam logic [31:0] CNT_ADDR  = 32'hFFFF_F020;
    localparam logic [31:0] CMP_ADDR  = 32'hFFFF_F024;
    localparam logic [31:0] STAT_ADDR = 32'hFFFF_F028;

    logic [31:0]      ram_off;
    logic [DM_AW-1:0] widx;
    logic             is_ram, is_led, is_sw, is_cnt, is_cmp, is_stat, is_mmio;
    logic             wr_ok, ram_we;
    logic [3:0]       be;
    logic [31:0]      wdata, rword, ld_data;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      mem [0:(1<<DM_AW)-1];
    logic [SW_W-1:0]  sw_meta, sw_sync, sw_acc;
    logic [31:0]      psc, tmr_cnt, tmr_cmp;
    logic             tick;

    assign ram_off = addr - DM_BASE;
    assign is_ram  = (ram_off >> (DM_AW + 2)) == 32'd0;
    assign widx    = ram_off[DM_AW+1:2];
    assign is_led  = (addr == LED_ADDR);
    assign is_sw   = (addr == SW_ADDR);
    assign is_cnt  = (addr == CNT_ADDR);
    assign is_cmp  = (addr == CMP_ADDR);
    assign is_stat = (addr == STAT_ADDR);
    assign is_mmio = is_led | is_sw | is_cnt | is_cmp | is_stat;

    // MMIO registers only accept full-word accesses.
    assign misalign_o = ((size == 2'b01) && addr[0])
                      || (size[1] && (addr[1:0] != 2'b00))
                      || (is_mmio && !size[1]);
    assign wr_ok  = wen && !misalign_o;
    assign ram_we = wr_ok && is_ram && !rst_i;

    // NOTE: always_comb assigns every output a default first so no latch is inferred.
    always_comb begin
        be    = 4'b1111;
        wdata = datain;
        if (size == 2'b00) begin
            be    = 4'b0001 << addr[1:0];
            wdata = {4{datain[7:0]}};
        end else if (size == 2'b01) begin
            be    = 4'b0011 << {addr[1], 1'b0};
            wdata = {2{datain[15:0]}};
        end
    end

    // NOTE: RAM contents are deliberately not reset; only the write is gated by rst_i.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rword  = mem[widx];
    assign lane_b = 8'(rword >> {addr[1:0], 3'b000});
    assign lane_h = 16'(rword >> {addr[1], 4'b0000});

    always_comb begin
        ld_data = rword;
        if (size == 2'b00)
            ld_data = ld_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
        else if (size == 2'b01)
            ld_data = ld_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
    end

    always_comb begin
        dataout = 32'd0;
        if (!misalign_o) begin
            if (is_ram)       dataout = ld_data;
            else if (is_led)  dataout = 32'(device_led);
            else if (is_sw)   dataout = 32'(sw_acc);
            else if (is_cnt)  dataout = tmr_cnt;
            else if (is_cmp)  dataout = tmr_cmp;
            else if (is_stat) dataout = {31'd0, tmr_flag_o};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            device_led <= '0;
        end else if (wr_ok && is_led) begin
            device_led <= datain[LED_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= device_sw;
            sw_sync <= sw_meta;
        end
    end

`ifdef SW_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES);

    logic [SW_W-1:0]  sw_prev;
    logic [DEB_W-1:0] deb_cnt;

    // Accept on the edge where the counter reaches DEB_CYCLES-1, giving 2+DEB_CYCLES latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_prev <= '0;
            deb_cnt <= '0;
            sw_acc  <= '0;
        end else begin
            sw_prev <= sw_sync;
            if (sw_sync != sw_prev) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_W'(DEB_CYCLES - 1)) begin
                deb_cnt <= deb_cnt + 1'b1;
                if (deb_cnt == DEB_W'(DEB_CYCLES - 2)) sw_acc <= sw_sync;
            end
        end
    end
`else
    assign sw_acc = sw_sync;
`endif

    assign tick = (psc == 32'(TMR_PRESCALE - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psc        <= '0;
            tmr_cnt    <= '0;
            tmr_cmp    <= 32'hFFFF_FFFF;
            tmr_flag_o <= 1'b0;
        end else begin
            if (wr_ok && is_cnt) begin
                tmr_cnt <= datain;
                psc     <= '0;
            end else if (tick) begin
                tmr_cnt <= tmr_cnt + 32'd1;
                psc     <= '0;
            end else begin
                psc <= psc + 32'd1;
            end
            if (wr_ok && is_cmp) tmr_cmp <= datain;
            // A compare hit on this tick beats a simultaneous write-1-to-clear.
            if (tick && !(wr_ok && is_cnt) && ((tmr_cnt + 32'd1) == tmr_cmp))
                tmr_flag_o <= 1'b1;
            else if (wr_ok && is_stat && datain[0])
                tmr_flag_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_bus.sv
// Self-checking bench for dmem_mmio_bus: directed MMIO/timer steps plus randomized RAM
// traffic compared against a byte-array model.
module tb_dmem_mmio_bus;
    localparam logic [31:0] DM_BASE      = 32'h0000_4000;
    localparam int          DM_AW        = 8;
    localparam int          RAM_BYTES    = 4 << DM_AW;
    localparam int          LED_W        = 12;
    localparam int          SW_W         = 24;
    localparam int          DEB_CYCLES   = 4;
    localparam int          TMR_PRESCALE = 2;
    localparam logic [31:0] A_LED  = 32'hFFFF_F000;
    localparam logic [31:0] A_SW   = 32'hFFFF_F070;
    localparam logic [31:0] A_CNT  = 32'hFFFF_F020;
    localparam logic [31:0] A_CMP  = 32'hFFFF_F024;
    localparam logic [31:0] A_STAT = 32'hFFFF_F028;
`ifdef SW_DEBOUNCE_EN
    localparam int SW_LAT = 2 + DEB_CYCLES;
`else
    localparam int SW_LAT = 2;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [31:0]      addr = 32'd0;
    logic             wen = 1'b0;
    logic [1:0]       size = 2'b10;
    logic             ld_unsigned = 1'b0;
    logic [31:0]      datain = 32'd0;
    logic [SW_W-1:0]  device_sw = '0;
    logic [31:0]      dataout;
    logic [LED_W-1:0] device_led;
    logic             misalign_o;
    logic             tmr_flag_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ram_m [RAM_BYTES];

    dmem_mmio_bus #(
        .DM_BASE(DM_BASE), .DM_AW(DM_AW), .LED_W(LED_W), .SW_W(SW_W),
        .DEB_CYCLES(DEB_CYCLES), .TMR_PRESCALE(TMR_PRESCALE)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr(addr), .wen(wen), .size(size),
        .ld_unsigned(ld_unsigned), .datain(datain), .device_sw(device_sw),
        .dataout(dataout), .device_led(device_led), .misalign_o(misalign_o),
        .tmr_flag_o(tmr_flag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_mis(input int off, input logic [1:0] sz);
        return (off % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input int off, input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) v |= 32'(ram_m[off+i]) << (8*i);
        if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
        return v;
    endfunction

    task automatic model_store(input int off, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) ram_m[off+i] = d[8*i +: 8];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drives a store for one edge; m is misalign_o sampled before the edge.
    task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                         output logic m);
        addr = a; size = sz; datain = d; wen = 1'b1;
        #1 m = misalign_o;
        @(posedge clk_i);
        #1 wen = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input bit uns,
                        output logic [31:0] d, output logic m);
        addr = a; size = sz; ld_unsigned = uns; wen = 1'b0;
        #1;
        d = dataout;
        m = misalign_o;
    endtask

    initial begin
        logic [31:0] d, v, cnt0;
        logic        m;
        logic [1:0]  sz;
        int          off;
        bit          uns;

        #1 rst_i = 1'b1;
        #1;
        check("rst_led", 32'(device_led), 32'd0);
        check("rst_flag", 32'(tmr_flag_o), 32'd0);
        load(A_CNT, 2'b10, 1'b0, d, m);  check("rst_cnt", d, 32'd0);
        load(A_CMP, 2'b10, 1'b0, d, m);  check("rst_cmp", d, 32'hFFFF_FFFF);
        load(A_SW, 2'b10, 1'b0, d, m);   check("rst_sw", d, 32'd0);
        step(2);
        rst_i = 1'b0;

        for (int w = 0; w < (1 << DM_AW); w++) begin
            v = $urandom;
            store(DM_BASE + 32'(4*w), 2'b10, v, m);
            model_store(4*w, 2'b10, v);
        end

        store(DM_BASE, 2'b10, 32'h1122_3344, m);     model_store(0, 2'b10, 32'h1122_3344);
        store(DM_BASE + 1, 2'b00, 32'hDEAD_BEAA, m); model_store(1, 2'b00, 32'hDEAD_BEAA);
        load(DM_BASE, 2'b10, 1'b0, d, m);     check("sb_word", d, 32'h1122_AA44);
        load(DM_BASE + 1, 2'b00, 1'b0, d, m); check("lb", d, 32'hFFFF_FFAA);
        load(DM_BASE + 1, 2'b00, 1'b1, d, m); check("lbu", d, 32'h0000_00AA);
        load(DM_BASE + 2, 2'b01, 1'b0, d, m); check("lh_hi", d, 32'h0000_1122);
        step(1);

        store(DM_BASE + 3, 2'b01, 32'h0000_5555, m); check("sh_mis_flag", 32'(m), 32'd1);
        load(DM_BASE + 3, 2'b01, 1'b0, d, m);        check("lh_mis_data", d, 32'd0);
        load(DM_BASE, 2'b10, 1'b0, d, m);            check("sh_mis_nowr", d, 32'h1122_AA44);
        step(1);

        store(A_LED, 2'b10, 32'h0000_00F0, m);  check("led_f0", 32'(device_led), 32'h0F0);
        store(A_LED, 2'b10, 32'hABCD_E123, m);  check("led_trunc", 32'(device_led), 32'h123);
        load(A_LED, 2'b10, 1'b0, d, m);         check("led_read", d, 32'h0000_0123);
        store(A_LED, 2'b00, 32'h0000_0055, m);  check("led_sb_mis", 32'(m), 32'd1);
        check("led_sb_nowr", 32'(device_led), 32'h123);

        load(32'hFFFF_F004, 2'b10, 1'b0, d, m);   check("unmapped", d, 32'd0);
        load(DM_BASE + RAM_BYTES, 2'b10, 1'b0, d, m); check("ram_above", d, 32'd0);
        load(DM_BASE - 4, 2'b10, 1'b0, d, m);     check("ram_below", d, 32'd0);
        step(1);
        store(DM_BASE + RAM_BYTES, 2'b10, 32'h5A5A_5A5A, m);
        load(DM_BASE, 2'b10, 1'b0, d, m);         check("no_alias", d, model_load(0, 2'b10, 1'b0));
        step(1);

        device_sw = 24'h00_00A5;
        for (int k = 1; k <= SW_LAT + 1; k++) begin
            step(1);
            load(A_SW, 2'b10, 1'b0, d, m);
            check("sw_lat", d, (k >= SW_LAT) ? 32'h0000_00A5 : 32'd0);
        end
`ifdef SW_DEBOUNCE_EN
        device_sw = 24'h5A_5A5A;
        step(DEB_CYCLES - 1);
        device_sw = 24'h00_00A5;
        for (int k = 0; k < 8; k++) begin
            step(1);
            load(A_SW, 2'b10, 1'b0, d, m);
            check("sw_glitch", d, 32'h0000_00A5);
        end
`endif
        v = 32'($urandom) & 32'h00FF_FFFF;
        device_sw = v[SW_W-1:0];
        step(SW_LAT - 1);
        load(A_SW, 2'b10, 1'b0, d, m);  check("sw_rand_old", d, 32'h0000_00A5);
        step(1);
        load(A_SW, 2'b10, 1'b0, d, m);  check("sw_rand_new", d, v);

        store(A_STAT, 2'b10, 32'd1, m);
        store(A_CMP, 2'b10, 32'd3, m);
        load(A_CMP, 2'b10, 1'b0, d, m);  check("cmp_read", d, 32'd3);
        store(A_CNT, 2'b10, 32'd0, m);
        load(A_CNT, 2'b10, 1'b0, d, m);  check("cnt_load", d, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            load(A_CNT, 2'b10, 1'b0, d, m);
            check("tmr_cnt", d, 32'(k / TMR_PRESCALE));
            check("tmr_flag", 32'(tmr_flag_o), 32'((k / TMR_PRESCALE) >= 3));
        end
        load(A_STAT, 2'b10, 1'b0, d, m); check("stat_read", d, 32'd1);
        store(A_STAT, 2'b10, 32'd2, m);  check("w0_keeps", 32'(tmr_flag_o), 32'd1);

        store(A_CNT, 2'b10, 32'd0, m);
        step(TMR_PRESCALE * 3 - 1);
        store(A_STAT, 2'b10, 32'd1, m);  check("set_wins", 32'(tmr_flag_o), 32'd1);
        store(A_STAT, 2'b10, 32'd1, m);  check("w1c", 32'(tmr_flag_o), 32'd0);

        cnt0 = 32'hFFFF_FFFF;
        store(A_CNT, 2'b10, cnt0, m);
        for (int k = 0; k <= TMR_PRESCALE; k++) begin
            if (k > 0) step(1);
            load(A_CNT, 2'b10, 1'b0, d, m);
            check("cnt_wrap", d, cnt0 + 32'(k / TMR_PRESCALE));
        end
        check("wrap_noflag", 32'(tmr_flag_o), 32'd0);

        for (int it = 0; it < 300; it++) begin
            sz  = 2'($urandom_range(0, 3));
            off = $urandom_range(0, RAM_BYTES - 1);
            if ($urandom_range(0, 3) != 0) off = off - (off % nbytes(sz));
            uns = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                store(DM_BASE + 32'(off), sz, v, m);
                check("rnd_st_mis", 32'(m), 32'(model_mis(off, sz)));
                if (!model_mis(off, sz)) model_store(off, sz, v);
            end else begin
                load(DM_BASE + 32'(off), sz, uns, d, m);
                check("rnd_ld_mis", 32'(m), 32'(model_mis(off, sz)));
                check("rnd_ld", d, model_mis(off, sz) ? 32'd0 : model_load(off, sz, uns));
                step(1);
            end
        end

        store(A_LED, 2'b10, 32'h0000_0007, m);
        store(A_CMP, 2'b10, 32'd3, m);
        store(A_CNT, 2'b10, 32'd2, m);
        step(TMR_PRESCALE);
        check("pre_rst_led", 32'(device_led), 32'h007);
        check("pre_rst_flag", 32'(tmr_flag_o), 32'd1);
        v = ~model_load(8, 2'b10, 1'b0);
        addr = DM_BASE + 8; size = 2'b10; datain = v; wen = 1'b1;
        #1 rst_i = 1'b1;
        #1;
        check("async_led", 32'(device_led), 32'd0);
        check("async_flag", 32'(tmr_flag_o), 32'd0);
        @(posedge clk_i);
        #1;
        load(A_CNT, 2'b10, 1'b0, d, m);  check("async_cnt", d, 32'd0);
        load(A_CMP, 2'b10, 1'b0, d, m);  check("async_cmp", d, 32'hFFFF_FFFF);
        rst_i = 1'b0;
        step(1);
        load(DM_BASE + 8, 2'b10, 1'b0, d, m); check("rst_store_drop", d, model_load(8, 2'b10, 1'b0));
        load(DM_BASE, 2'b10, 1'b0, d, m);     check("ram_kept", d, model_load(0, 2'b10, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
